// File: rtl/serial_adder_if.sv
// Handshake and data bundle between a requester and the bit-serial adder.
// The requester drives operands and start; the adder returns status and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB first, with a
// registered carry between bits and registered sum/carry-out/overflow results.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] resShift;
    logic [WIDTH-1:0] resNext;
    logic             carry;
    logic             carryNext;
    logic             sumBit;
    logic             lastBit;
    logic [CNT_W-1:0] bitCount;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        sumBit    = opA[0] ^ opB[0] ^ carry;
        carryNext = (opA[0] & opB[0]) | (opA[0] & carry) | (opB[0] & carry);
        resNext   = {sumBit, resShift[WIDTH-1:1]};
        lastBit   = (bitCount == LAST_BIT);
        case (state)
            IDLE:    if (bus.start) stateNext = RUN;
            RUN:     if (lastBit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opA      <= '0;
            opB      <= '0;
            resShift <= '0;
            carry    <= 1'b0;
            bitCount <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            state    <= stateNext;
            bus.busy <= (stateNext == RUN);
            bus.done <= (stateNext == DONE);
            if (state == IDLE && bus.start) begin
                opA      <= bus.a;
                opB      <= bus.b;
                carry    <= bus.cin;
                bitCount <= '0;
            end else if (state == RUN) begin
                opA      <= opA >> 1;
                opB      <= opB >> 1;
                resShift <= resNext;
                carry    <= carryNext;
                bitCount <= bitCount + CNT_W'(1);
                // carry still holds the carry into the MSB while the last bit is processed
                if (lastBit) begin
                    bus.sum  <= resNext;
                    bus.cout <= carryNext;
                    bus.ovf  <= carry ^ carryNext;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8): arithmetic corners,
// handshake timing, ignored restart, held start and mid-run reset.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    logic [WIDTH-1:0] lastSum;
    logic lastCout;
    logic lastOvf;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Launch one addition and check timing, held results during RUN, and final results.
    task automatic runAdd(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] expSum, input logic expCout, input logic expOvf);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.cin   = ~cin;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, bus.busy, 1);
            check({tag, "_nodone"}, bus.done, 0);
            if (i == 0 || i == WIDTH - 1) check({tag, "_sumhold"}, bus.sum, lastSum);
        end
        @(negedge clk);
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_busyoff"}, bus.busy, 0);
        check({tag, "_sum"}, bus.sum, expSum);
        check({tag, "_cout"}, bus.cout, expCout);
        check({tag, "_ovf"}, bus.ovf, expOvf);
        lastSum  = expSum;
        lastCout = expCout;
        lastOvf  = expOvf;
    endtask

    initial begin
        int doneSeen;
        checkCount = 0;
        passCount  = 0;
        lastSum    = '0;
        lastCout   = 1'b0;
        lastOvf    = 1'b0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cin    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;

        runAdd("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        runAdd("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        runAdd("addff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        runAdd("add7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        runAdd("add80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Ignored restart during RUN, then start held high until the next acceptance.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        doneSeen  = 0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
            if (i == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
            end
            if (i == 8) begin
                check("ign_done", bus.done, 1);
                check("ign_sum", bus.sum, 8'h30);
                check("ign_cout", bus.cout, 0);
            end
            if (i == 9) check("held_idle", bus.busy, 0);
            if (i == 10) check("held_accept", bus.busy, 1);
        end
        check("ign_donecount", doneSeen, 1);
        bus.start = 1'b0;
        for (int i = 11; i <= 18; i++) @(negedge clk);
        check("held_done", bus.done, 1);
        check("held_sum", bus.sum, 8'hFF);
        check("held_ovf", bus.ovf, 0);
        lastSum = 8'hFF;

        // Mid-run reset aborts the operation.
        runAdd("pre_rst", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("arst_busy", bus.busy, 0);
        check("arst_sum", bus.sum, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        check("abort_nodone", doneSeen, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_ovf", bus.ovf, 0);
        lastSum = '0;
        runAdd("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial two's-complement adder. Captures two WIDTH-bit operands and a carry-in, then adds one bit per clock, LSB first.
- Each bit position uses one full-adder cell with a registered carry between bits.
- Sits upstream of the result consumer and replaces a WIDTH-wide ripple chain with a single full-adder cell plus shift registers and control.
- Exposes a start/busy/done handshake and registered sum, carry-out and signed-overflow results.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled on the rising edge, accepted only in IDLE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while bits are being processed (state RUN).
- done  output  1  single-cycle pulse; results valid from this cycle onward.
- sum  output  WIDTH  registered sum of the last completed operation.
- cout  output  1  registered carry-out of the MSB.
- ovf  output  1  registered signed overflow, equal to carry-into-MSB XOR cout.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of state:
  - state IDLE;
  - busy=0, done=0;
  - sum=0, cout=0, ovf=0;
  - internal shift registers, bit counter and carry register cleared.
- FSM states and transitions:
  - IDLE: if start=1 at edge k, load shift regs with a and b, load carry reg with cin, clear counter, go to RUN. Otherwise stay.
  - RUN: each edge adds the LSB of each shift reg plus the carry reg through the full-adder cell.
    - Shift the sum bit into the MSB of the result shift reg.
    - Shift both operand regs right by 1.
    - Update the carry reg.
    - Increment the counter.
    - On the edge that processes bit WIDTH-1 (edge k+WIDTH):
      - Transfer the result shift reg (including that bit) to sum.
      - Set cout to the new carry.
      - Set ovf to the carry into bit WIDTH-1 XOR the new carry.
      - Go to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge k. busy=1 during the WIDTH cycles following edges k..k+WIDTH-1. done=1 during the cycle following edge k+WIDTH. Earliest next accepted start is edge k+WIDTH+2.
- busy is a registered decode of state RUN; done is a registered decode of state DONE. Neither is combinational on start.
- start while in RUN or DONE is ignored: no restart, operands unchanged, no queuing.
- a, b and cin may change freely after the accepting edge without affecting the result.
- sum, cout and ovf hold their previous values throughout RUN and are updated only at the completing edge. They hold until the next completion or reset.
- Arithmetic: the result is {cout, sum} = a + b + cin modulo 2^(WIDTH+1), so the WIDTH-bit sum wraps.
- The counter width is enough to hold WIDTH-1. The counter does not wrap inside one operation.
- Reset asserted mid-RUN aborts the operation. No done is produced, and sum, cout and ovf go to 0.
- start held high continuously: an addition is accepted every WIDTH+2 cycles (each pass through IDLE).

Test Plan:
- WIDTH=8, reset released, then a=0x35, b=0x4A, cin=0, start pulsed at edge k.
  - busy=1 for 8 cycles, done=1 in the cycle after edge k+8.
  - sum=0x7F, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- Start accepted with a=0x10, b=0x20; at edge k+3 drive start=1 with a=0xAA, b=0x55.
  - The second request is ignored; done pulses once with sum=0x30.
  - With start then held high, the next acceptance occurs at edge k+10.
- Prior result sum=0x7F; start accepted; rst_n driven low at edge k+4 for one cycle, then released.
  - busy=0, done never pulses, sum=0x00, cout=0, ovf=0.
  - A fresh start with a=0x01, b=0x02 yields sum=0x03 after 8 cycles.
